tone_alert_gen: RTL and testbench
=================================

# tone_alert_gen

Parametrised audible-alert generator for the water-reminder buzzer path. On a start request it latches a tone half-period, beep on/off cadence and beep count, then drives a square wave onto the buzzer in timed bursts until the count is exhausted or a stop arrives. It replaces the ungated clock-to-buzzer path and the fixed free-running divider; the reminder controller drives `start`/`stop`, and `toBuzzer` goes straight to the buzzer pin.

## Interface
- DIV_W, 16, width of tone half-period input and tone counter
- BEEP_W, 24, width of on/off duration inputs and cadence counter
- CNT_W, 8, width of beep-count input and beep counter
- clk  in  1  system clock; all state changes on posedge
- reset  in  1  asynchronous, active-high; forces IDLE and clears every register
- start  in  1  request; sampled only in IDLE; latches all configuration inputs
- stop  in  1  abort; valid in any state; takes priority over start
- halfPeriod  in  DIV_W  tone half-period in clk cycles; 0 = silent beeps
- onTime  in  BEEP_W  cycles per beep; 0 coerced to 1 at latch
- offTime  in  BEEP_W  gap cycles between beeps; 0 = no gap
- beepCount  in  CNT_W  beeps per alert; 0 = continuous until stop
- toBuzzer  out  1  registered square-wave drive
- busy  out  1  high whenever state is not IDLE
- beepOn  out  1  high while in ON (LED mirror)
- done  out  1  one-cycle pulse on normal completion

## Operation
- Reset values: state IDLE; toBuzzer, busy, beepOn, done = 0; all counters and latched config = 0.
- States: IDLE, ON, OFF.
- IDLE: start=1 and stop=0 at an edge -> latch halfPeriod, onTime (0->1), offTime, beepCount; clear beep counter, phase counter, tone counter, tone register; go ON.
- ON: phase counter increments each edge. At the edge where phase == onTime-1: beep counter += 1; if beepCount != 0 and new beep counter == beepCount -> IDLE with done=1; else if offTime == 0 -> re-enter ON (phase, tone counter and tone register cleared); else -> OFF (phase cleared).
- OFF: phase counter increments; at phase == offTime-1 -> ON (phase, tone counter and tone register cleared).
- Tone (ON only): tone counter increments each edge; at counter == halfPeriod-1 the tone register toggles and the counter clears. halfPeriod == 0: tone register held 0, cadence unchanged. Outside ON, tone register and counter held 0.
- toBuzzer = tone register. beepOn = (state == ON). busy = (state != IDLE).
- stop=1 at any edge -> IDLE; toBuzzer and beepOn 0 next cycle; done not asserted. start ignored in the same cycle.
- start while busy is ignored; configuration inputs are ignored while busy.
- beepCount == 0: the beep counter wraps modulo 2^CNT_W with no effect on behaviour.
- Reset asserted mid-alert: immediate return to reset values, no done pulse.

## Timing
- Start sampled at edge k: busy and beepOn high from edge k; toBuzzer low for the first halfPeriod cycles, then toggles every halfPeriod cycles (period 2*halfPeriod).
- Each ON phase lasts exactly onTime cycles; each OFF phase exactly offTime cycles. Each beep begins with the tone low.
- Total busy length for finite count N: N*onTime + (N-1)*offTime cycles (offTime > 0).
- done is high for exactly the one cycle following the edge that ends the final ON phase, the same cycle busy first reads 0.
- A new start is accepted no earlier than the edge after busy falls (no back-to-back acceptance on the completion edge).

## Test plan
- halfPeriod=2, onTime=8, offTime=4, beepCount=2, start at edge k -> toBuzzer 0,0,1,1,0,0,1,1 per beep, 4 zero cycles in the gap, busy high 20 cycles, done for 1 cycle after edge k+20.
- halfPeriod=3, onTime=5, offTime=0, beepCount=3 -> 15 busy cycles, tone restarts low at each beep (pattern 0,0,0,1,1 repeated 3 times), single done.
- beepCount=0, onTime=4, offTime=4; stop after 100 cycles -> continuous alternation, toBuzzer and busy 0 the cycle after stop, done never asserted.
- halfPeriod=0, onTime=0, offTime=2, beepCount=2 -> toBuzzer stays 0, beepOn high 1 cycle per beep, busy 4 cycles, done pulse.
- start and stop high together in IDLE -> stays IDLE; start re-pulsed during an alert with new config -> ignored, original cadence kept.
- reset asserted asynchronously mid-ON with toBuzzer=1 -> all outputs 0 immediately, no done; next start after reset behaves as the first scenario.

Source files
------------

// File: rtl/tone_alert_gen.sv
// tone_alert_gen
//   Audible-alert generator for the water-reminder buzzer path. A start
//   request latches a tone half-period, a beep on/off cadence and a beep
//   count. The block then drives a square wave onto the buzzer in timed
//   bursts until the count is exhausted or a stop arrives.
//
// Parameters
//   DIV_W   width of the tone half-period and the tone counter
//   BEEP_W  width of the on/off durations and the cadence (phase) counter
//   CNT_W   width of the beep count and the beep counter
//
// Ports
//   clk         system clock; all state changes on the rising edge
//   reset       asynchronous, active-high; returns everything to zero / IDLE
//   start       alert request; only sampled in IDLE; latches configuration
//   stop        abort; honoured in any state; wins over start
//   halfPeriod  tone half-period in clk cycles (0 = silent beeps)
//   onTime      cycles per beep (0 is treated as 1)
//   offTime     gap cycles between beeps (0 = beeps run back to back)
//   beepCount   beeps per alert (0 = continuous until stop)
//   toBuzzer    registered square-wave drive to the buzzer pin
//   busy        high whenever an alert is in progress
//   beepOn      high during the audible part of each beep (LED mirror)
//   done        one-cycle pulse when an alert completes normally
module tone_alert_gen #(
    parameter int DIV_W  = 16,
    parameter int BEEP_W = 24,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic [DIV_W-1:0]  halfPeriod,
    input  logic [BEEP_W-1:0] onTime,
    input  logic [BEEP_W-1:0] offTime,
    input  logic [CNT_W-1:0]  beepCount,
    output logic              toBuzzer,
    output logic              busy,
    output logic              beepOn,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } state_t;

    state_t state;

    // Configuration captured when the alert is accepted
    logic [DIV_W-1:0]  hp_lat;
    logic [BEEP_W-1:0] on_lat;
    logic [BEEP_W-1:0] off_lat;
    logic [CNT_W-1:0]  cnt_lat;

    // Running counters
    logic [CNT_W-1:0]  beep_cnt;
    logic [BEEP_W-1:0] phase;
    logic [DIV_W-1:0]  tone_cnt;
    logic              tone;

    logic              on_last;
    logic              off_last;
    logic              tone_wrap;
    logic [CNT_W-1:0]  beep_next;
    logic              final_beep;

    // on_lat is never 0 (coerced at latch), and OFF is only entered with
    // off_lat != 0, so the "-1" compares cannot underflow where they matter.
    assign on_last    = (phase == on_lat - BEEP_W'(1));
    assign off_last   = (phase == off_lat - BEEP_W'(1));
    assign tone_wrap  = (tone_cnt == hp_lat - DIV_W'(1));
    assign beep_next  = beep_cnt + CNT_W'(1);
    // With a count of 0 the beep counter just wraps and never ends the alert
    assign final_beep = (cnt_lat != '0) && (beep_next == cnt_lat);

    assign toBuzzer = tone;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            hp_lat   <= '0;
            on_lat   <= '0;
            off_lat  <= '0;
            cnt_lat  <= '0;
            beep_cnt <= '0;
            phase    <= '0;
            tone_cnt <= '0;
            tone     <= 1'b0;
            busy     <= 1'b0;
            beepOn   <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (stop) begin
                // Abort: silence at once, no completion pulse
                state    <= IDLE;
                phase    <= '0;
                tone_cnt <= '0;
                tone     <= 1'b0;
                busy     <= 1'b0;
                beepOn   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            hp_lat   <= halfPeriod;
                            on_lat   <= (onTime == '0) ? BEEP_W'(1) : onTime;
                            off_lat  <= offTime;
                            cnt_lat  <= beepCount;
                            beep_cnt <= '0;
                            phase    <= '0;
                            tone_cnt <= '0;
                            tone     <= 1'b0;
                            state    <= ON;
                            busy     <= 1'b1;
                            beepOn   <= 1'b1;
                        end
                    end

                    ON: begin
                        if (on_last) begin
                            // End of a beep: every beep restarts with tone low
                            beep_cnt <= beep_next;
                            phase    <= '0;
                            tone_cnt <= '0;
                            tone     <= 1'b0;
                            if (final_beep) begin
                                state  <= IDLE;
                                busy   <= 1'b0;
                                beepOn <= 1'b0;
                                done   <= 1'b1;
                            end else if (off_lat == '0) begin
                                state <= ON;
                            end else begin
                                state  <= OFF;
                                beepOn <= 1'b0;
                            end
                        end else begin
                            phase <= phase + BEEP_W'(1);
                            // A zero half-period keeps the beep silent but
                            // leaves the cadence untouched.
                            if (hp_lat != '0) begin
                                if (tone_wrap) begin
                                    tone     <= ~tone;
                                    tone_cnt <= '0;
                                end else begin
                                    tone_cnt <= tone_cnt + DIV_W'(1);
                                end
                            end
                        end
                    end

                    OFF: begin
                        if (off_last) begin
                            state    <= ON;
                            phase    <= '0;
                            tone_cnt <= '0;
                            tone     <= 1'b0;
                            beepOn   <= 1'b1;
                        end else begin
                            phase <= phase + BEEP_W'(1);
                        end
                    end

                    default: begin
                        state    <= IDLE;
                        phase    <= '0;
                        tone_cnt <= '0;
                        tone     <= 1'b0;
                        busy     <= 1'b0;
                        beepOn   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tone_alert_gen.sv
module tb_tone_alert_gen;

    localparam int DIV_W  = 16;
    localparam int BEEP_W = 24;
    localparam int CNT_W  = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              stop;
    logic [DIV_W-1:0]  halfPeriod;
    logic [BEEP_W-1:0] onTime;
    logic [BEEP_W-1:0] offTime;
    logic [CNT_W-1:0]  beepCount;
    logic              toBuzzer;
    logic              busy;
    logic              beepOn;
    logic              done;

    int total = 0;
    int bad   = 0;

    // Expected per-cycle outputs, packed as {toBuzzer, busy, beepOn, done}
    logic [3:0] exp_q[$];

    tone_alert_gen #(.DIV_W(DIV_W), .BEEP_W(BEEP_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .halfPeriod(halfPeriod), .onTime(onTime), .offTime(offTime),
        .beepCount(beepCount), .toBuzzer(toBuzzer), .busy(busy),
        .beepOn(beepOn), .done(done)
    );

    always #5 clk = ~clk;

    // Reference waveform built from the cadence rules: each beep is onTime
    // cycles of a square wave starting low, gaps are offTime silent busy
    // cycles, then one idle cycle carrying done, then plain idle.
    task automatic build(input int hp, input int on, input int off,
                         input int cnt, input int min_len);
        int on_e;
        int beeps;
        exp_q.delete();
        on_e  = (on == 0) ? 1 : on;
        beeps = (cnt == 0) ? 1000000 : cnt;
        for (int b = 0; b < beeps; b++) begin
            for (int i = 0; i < on_e; i++)
                exp_q.push_back({(hp == 0) ? 1'b0 : 1'(((i / hp) % 2)), 1'b1, 1'b1, 1'b0});
            if (cnt == 0 && exp_q.size() >= min_len) break;
            if (b != beeps - 1)
                for (int i = 0; i < off; i++) exp_q.push_back(4'b0100);
        end
        if (cnt != 0) exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0000);
        exp_q.push_back(4'b0000);
    endtask

    task automatic randomize_cfg();
        halfPeriod = DIV_W'($urandom);
        onTime     = BEEP_W'($urandom);
        offTime    = BEEP_W'($urandom);
        beepCount  = CNT_W'($urandom);
    endtask

    // Start an alert and follow it cycle by cycle. stop_after > 0 aborts a
    // continuous alert after that many cycles; pulse_at >= 0 re-pulses start
    // (with scrambled config) before the edge that follows that cycle.
    task automatic run_alert(input string name, input int hp, input int on,
                             input int off, input int cnt,
                             input int stop_after, input int pulse_at);
        int n;
        logic [3:0] obs;
        halfPeriod = DIV_W'(hp);
        onTime     = BEEP_W'(on);
        offTime    = BEEP_W'(off);
        beepCount  = CNT_W'(cnt);
        start = 1'b1;
        stop  = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        build(hp, on, off, cnt, stop_after);
        n = (cnt == 0) ? stop_after : exp_q.size();
        for (int j = 0; j < n; j++) begin
            obs = {toBuzzer, busy, beepOn, done};
            total++;
            if (obs !== exp_q[j]) begin
                bad++;
                $display("FAIL %s cyc=%0d got=%b exp=%b", name, j, obs, exp_q[j]);
            end
            randomize_cfg();
            start = (j == pulse_at);
            @(posedge clk); #1;
            start = 1'b0;
        end
        if (cnt == 0) begin
            stop = 1'b1;
            @(posedge clk); #1;
            stop = 1'b0;
            for (int j = 0; j < 3; j++) begin
                obs = {toBuzzer, busy, beepOn, done};
                total++;
                if (obs !== 4'b0000) begin
                    bad++;
                    $display("FAIL %s_after_stop cyc=%0d got=%b exp=0000", name, j, obs);
                end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; stop = 1'b0;
        halfPeriod = '0; onTime = '0; offTime = '0; beepCount = '0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({toBuzzer, busy, beepOn, done} !== 4'b0000) begin
            bad++;
            $display("FAIL reset got=%b exp=0000", {toBuzzer, busy, beepOn, done});
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        run_alert("basic", 2, 8, 4, 2, 0, -1);
        run_alert("no_gap", 3, 5, 0, 3, 0, -1);
        run_alert("silent_min", 0, 0, 2, 2, 0, -1);
    endtask

    task automatic test_continuous_stop();
        run_alert("continuous", 3, 4, 4, 0, 100, -1);
    endtask

    task automatic test_start_stop_idle();
        halfPeriod = 16'd2; onTime = 24'd8; offTime = 24'd4; beepCount = 8'd2;
        start = 1'b1; stop = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; stop = 1'b0;
        for (int j = 0; j < 3; j++) begin
            total++;
            if ({toBuzzer, busy, beepOn, done} !== 4'b0000) begin
                bad++;
                $display("FAIL start_stop_idle cyc=%0d got=%b exp=0000", j, {toBuzzer, busy, beepOn, done});
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_ignore_start();
        run_alert("ignore_start", 2, 8, 4, 2, 0, 3);
    endtask

    // Start held on the completing edge must not be accepted
    task automatic test_back_to_back();
        run_alert("back_to_back", 2, 8, 4, 2, 0, 19);
    endtask

    task automatic test_async_reset();
        logic [3:0] obs;
        halfPeriod = 16'd2; onTime = 24'd8; offTime = 24'd4; beepCount = 8'd2;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        obs = {toBuzzer, busy, beepOn, done};
        total++;
        if (obs !== 4'b1110) begin
            bad++;
            $display("FAIL pre_reset_tone got=%b exp=1110", obs);
        end
        #2 reset = 1'b1;
        #1;
        obs = {toBuzzer, busy, beepOn, done};
        total++;
        if (obs !== 4'b0000) begin
            bad++;
            $display("FAIL async_reset got=%b exp=0000", obs);
        end
        @(posedge clk); #1;
        obs = {toBuzzer, busy, beepOn, done};
        total++;
        if (obs !== 4'b0000) begin
            bad++;
            $display("FAIL reset_held got=%b exp=0000", obs);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        run_alert("after_reset", 2, 8, 4, 2, 0, -1);
    endtask

    task automatic test_random();
        for (int it = 0; it < 12; it++) begin
            int hp, on, off, cnt;
            hp  = int'($urandom_range(0, 4));
            on  = int'($urandom_range(0, 9));
            off = int'($urandom_range(0, 5));
            cnt = int'($urandom_range(0, 4));
            if (cnt == 0)
                run_alert("rand_cont", hp, on, off, 0, int'($urandom_range(1, 40)), -1);
            else
                run_alert("rand", hp, on, off, cnt, 0, -1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_continuous_stop();
        test_start_stop_idle();
        test_ignore_start();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
